// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core's M stage: word RAM in the low half, MMIO (cycle counter, LEDs,
// console FIFO, error address) in the high half. Optional store-alignment checking: DMEM_ALIGN_CHECK_EN.
module dmem_mmio_responder #(
    parameter int RAM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic [15:0] led,
    output logic        align_err
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [31:0]   A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0]   A_CON    = 32'h8000_0004;
    localparam logic [31:0]   A_STATUS = 32'h8000_0008;
    localparam logic [31:0]   A_LED    = 32'h8000_000C;
    localparam logic [31:0]   A_ERR    = 32'h8000_0010;

    logic [31:0]   r_ram [0:RAM_DEPTH-1];
    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [31:0]   r_cycle;
    logic [15:0]   r_led;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic [31:0]   w_word_addr;
    logic [AW-1:0] w_ram_idx;
    logic          w_misalign;
    logic          w_store;
    logic          w_st_ram;
    logic          w_st_cycle;
    logic          w_st_led;
    logic          w_st_status;
    logic          w_push_req;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_err_addr;
    logic [31:0]   w_rdata;

    assign w_word_addr = {mem_addr[31:2], 2'b00};
    assign w_ram_idx   = mem_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic          r_aerr;
    logic [31:0]   r_eaddr;

    assign w_misalign = (mem_addr[1:0] != 2'b00);

    // Sticky alignment error; the address of the first offending store is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aerr  <= 1'b0;
            r_eaddr <= 32'h0000_0000;
        end else if (mem_we & w_misalign) begin
            r_aerr <= 1'b1;
            if (!r_aerr) begin
                r_eaddr <= mem_addr;
            end
        end
    end

    assign align_err  = r_aerr;
    assign w_err_addr = r_eaddr;
`else
    logic w_unused_lo;
    assign w_unused_lo = ^mem_addr[1:0];
    assign w_misalign  = 1'b0;
    assign align_err   = 1'b0;
    assign w_err_addr  = 32'h0000_0000;
`endif

    assign w_store     = mem_we & ~w_misalign;
    assign w_st_ram    = w_store & ~mem_addr[31];
    assign w_st_cycle  = w_store & (w_word_addr == A_CYCLE);
    assign w_st_led    = w_store & (w_word_addr == A_LED);
    assign w_st_status = w_store & (w_word_addr == A_STATUS);
    assign w_push_req  = w_store & (w_word_addr == A_CON);

    assign w_empty = (r_count == CNT_ZERO);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = ~w_empty & con_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    // RAM array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_st_ram) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
    end

    // Console FIFO storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= mem_wdata[7:0];
        end
    end

    // MMIO registers and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= 32'h0000_0000;
            r_led   <= 16'h0000;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_cycle <= w_st_cycle ? mem_wdata : (r_cycle + 32'd1);
            if (w_st_led) begin
                r_led <= mem_wdata[15:0];
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= r_count + (w_push ? CNT_ONE : CNT_ZERO) - (w_pop ? CNT_ONE : CNT_ZERO);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_st_status & mem_wdata[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Combinational load path showing pre-edge state.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (!mem_addr[31]) begin
            w_rdata = r_ram[w_ram_idx];
        end else begin
            case (w_word_addr)
                A_CYCLE:  w_rdata = r_cycle;
                A_STATUS: w_rdata = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
                A_LED:    w_rdata = {16'h0000, r_led};
                A_ERR:    w_rdata = w_err_addr;
                default:  w_rdata = 32'h0000_0000;
            endcase
        end
    end

    assign mem_rdata = w_rdata;
    assign con_valid = ~w_empty;
    assign con_data  = r_fifo[r_rptr];
    assign led       = r_led;

endmodule
